rotate_amount_finder: RTL and testbench
=======================================

// Module: rotate_amount_finder
// PURPOSE
// - Inverse of the 32-bit left/right rotator: given an original word, a rotated word and a direction,
//   finds the smallest rotate amount s such that rotate_dir(orig, s) == rot.
// - Iterative: one candidate per clock, valid/ready on both sides. Used by the rotator's checker path
//   and by datapath logic that must recover an applied rotation.
// PARAMETERS
// - WIDTH  32  data width, power of two >= 2; SHW = $clog2(WIDTH) is a derived localparam
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      request valid
// - in_ready   out  1      block can accept a request (high only in IDLE)
// - orig_data  in   WIDTH  unrotated word
// - rot_data   in   WIDTH  rotated word to match
// - dir        in   1      0 = left rotate, 1 = right rotate (same encoding as sel_left_or_right_rotate)
// - out_valid  out  1      result valid, held until accepted
// - out_ready  in   1      consumer accepts result
// - found      out  1      1 = a matching amount exists
// - shift_amt  out  SHW    smallest matching amount in dir's sense; 0 when found=0
// BEHAVIOUR
// - One clock and one synchronous, active-high reset: clk/rst. On rst, the state goes to IDLE and
//   out_valid=0, found=0, shift_amt=0; in_ready=1 from the first cycle after reset.
// - Reset asserted mid-search or in DONE aborts the request; no result is ever emitted for it.
// - FSM IDLE -> SEARCH -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready (cycle T), capture into registers: work<=orig_data,
//     target<=rot_data, dir_q<=dir, cnt<=0. Go to SEARCH.
//   SEARCH: each cycle compare work==target.
//     Match: found<=1, shift_amt<=cnt, go to DONE.
//     No match and cnt==WIDTH-1: found<=0, shift_amt<=0, go to DONE.
//     Otherwise: work<=rotate work by 1 in dir_q's direction, cnt<=cnt+1.
//   DONE: out_valid=1; found and shift_amt stay stable. On out_ready, go to IDLE.
//     in_ready is not re-asserted in the same cycle, so there are no back-to-back accepts.
// - Latency: a match at amount k gives out_valid at T+2+k (minimum T+2 for k=0).
//   No match gives out_valid at T+1+WIDTH (T+33 for WIDTH=32).
// - Inputs are sampled only at accept; changes to orig_data, rot_data or dir during SEARCH/DONE are ignored.
// - Periodic patterns match several amounts; the smallest is reported. orig==rot always reports found=1, amt=0.
// - Right amount s corresponds to left amount (WIDTH-s) mod WIDTH. No conversion is done; the result
//   is in dir_q's sense.
// - cnt is SHW+1 bits wide or saturates at WIDTH-1; it must never wrap to 0 inside SEARCH.
// STRUCTURE
// - Shared package: state enum {IDLE,SEARCH,DONE}, the DIR_LEFT=0 / DIR_RIGHT=1 constants and the
//   WIDTH-derived SHW function. The rotator family uses the same package.
// - No sub-module: the 1-bit rotate step and the WIDTH-bit equality compare stay inline.
//   A full barrel rotator is deliberately not instantiated.
// TESTING
// - orig=0x0000_0001, rot=0x0000_0010, dir=0 -> found=1, shift_amt=4, out_valid at T+6
// - orig=0x8000_0001, rot=0xC000_0000, dir=1 -> found=1, shift_amt=1, out_valid at T+3
// - orig=0x1234_5678, rot=0x1234_5679, dir=0 -> found=0, shift_amt=0, out_valid at T+33
// - orig=0xAAAA_AAAA, rot=0x5555_5555, dir=0 -> found=1, shift_amt=1 (smallest);
//   orig=rot=0 -> found=1, shift_amt=0 at T+2
// - Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, found and shift_amt stable,
//   in_ready=0, in_valid ignored. Raise out_ready -> in_ready=1 the next cycle.
// - Assert rst at T+10 during a no-match search -> next cycle out_valid=0 and in_ready=1.
//   A new request (orig=0x0000_00F0, rot=0x0000_000F, dir=1) -> found=1, shift_amt=4. Scoreboard
//   compares against a reference model: rotate orig 0..WIDTH-1 and take the first match.

Source files
------------

// File: rtl/rotate_amount_finder_pkg.sv
// Shared types and constants for the rotator family.
// Direction encoding matches sel_left_or_right_rotate.
package rotate_amount_finder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } finderState;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic int shwOf(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/rotate_amount_finder.sv
// Recovers the smallest rotate amount mapping orig to rot,
// testing one candidate per clock with valid/ready on both sides.
module rotate_amount_finder
  import rotate_amount_finder_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = shwOf(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] orig_data,
  input  logic [WIDTH-1:0] rot_data,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             found,
  output logic [SHW-1:0]   shift_amt
);

  // cnt carries one spare bit so it can never wrap inside SEARCH
  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

  finderState       state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] target;
  logic             dirQ;
  logic [SHW:0]     cnt;

  logic [WIDTH-1:0] stepped;
  logic             hit;

  // Single-bit rotate of the working word and the candidate compare
  always_comb begin
    stepped = work;
    if (dirQ == DIR_RIGHT) begin
      stepped = {work[0], work[WIDTH-1:1]};
    end else begin
      stepped = {work[WIDTH-2:0], work[WIDTH-1]};
    end
    hit = (work == target);
  end

  // Search FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      found     <= 1'b0;
      shift_amt <= '0;
      work      <= '0;
      target    <= '0;
      dirQ      <= DIR_LEFT;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work      <= orig_data;
            target    <= rot_data;
            dirQ      <= dir;
            cnt       <= '0;
            found     <= 1'b0;
            shift_amt <= '0;
            in_ready  <= 1'b0;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            found     <= 1'b1;
            shift_amt <= cnt[SHW-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == LAST) begin
            found     <= 1'b0;
            shift_amt <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            work <= stepped;
            cnt  <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_amount_finder.sv
// Directed bench for rotate_amount_finder.
// Latency is counted in cycles after the accept edge.
module tb_rotate_amount_finder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] orig_data;
  logic [31:0] rot_data;
  logic        dir;
  logic        out_valid;
  logic        out_ready;
  logic        found;
  logic [4:0]  shift_amt;

  int checks;
  int errors;

  rotate_amount_finder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .orig_data (orig_data),
    .rot_data  (rot_data),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .found     (found),
    .shift_amt (shift_amt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void refFind(
    input  logic [31:0] o,
    input  logic [31:0] r,
    input  logic        d,
    output logic        f,
    output logic [4:0]  a
  );
    logic [31:0] w;
    f = 1'b0;
    a = 5'd0;
    w = o;
    for (int i = 0; i < 32; i++) begin
      if (w == r) begin
        f = 1'b1;
        a = 5'(i);
        break;
      end
      w = d ? {w[0], w[31:1]} : {w[30:0], w[31]};
    end
  endfunction

  task automatic doReq(
    input  logic [31:0] o,
    input  logic [31:0] r,
    input  logic        d,
    output int          lat
  );
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready: got %b want 1", in_ready);
    end
    in_valid  = 1'b1;
    orig_data = o;
    rot_data  = r;
    dir       = d;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    orig_data = $urandom;
    rot_data  = $urandom;
    dir       = ~d;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL timeout: no out_valid within 40 cycles");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic checkResult(
    input string       name,
    input logic        expF,
    input logic [4:0]  expA,
    input int          expLat,
    input int          lat
  );
    checks++;
    if (found !== expF) begin
      errors++;
      $display("FAIL %s found: got %b want %b", name, found, expF);
    end
    checks++;
    if (shift_amt !== expA) begin
      errors++;
      $display("FAIL %s amt: got %0d want %0d", name, shift_amt, expA);
    end
    checks++;
    if (lat != expLat) begin
      errors++;
      $display("FAIL %s latency: got T+%0d want T+%0d", name, lat, expLat);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    orig_data = '0;
    rot_data  = '0;
    dir       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        found !== 1'b0 || shift_amt !== 5'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b f=%b a=%0d want 1/0/0/0",
               in_ready, out_valid, found, shift_amt);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vo [5];
    logic [31:0] vr [5];
    logic        vd [5];
    logic        vf [5];
    logic [4:0]  va [5];
    int          vl [5];
    int          lat;
    logic        mf;
    logic [4:0]  ma;
    vo[0] = 32'h0000_0001; vr[0] = 32'h0000_0010; vd[0] = 1'b0;
    vf[0] = 1'b1; va[0] = 5'd4; vl[0] = 6;
    vo[1] = 32'h8000_0001; vr[1] = 32'hC000_0000; vd[1] = 1'b1;
    vf[1] = 1'b1; va[1] = 5'd1; vl[1] = 3;
    vo[2] = 32'h1234_5678; vr[2] = 32'h1234_5679; vd[2] = 1'b0;
    vf[2] = 1'b0; va[2] = 5'd0; vl[2] = 33;
    vo[3] = 32'hAAAA_AAAA; vr[3] = 32'h5555_5555; vd[3] = 1'b0;
    vf[3] = 1'b1; va[3] = 5'd1; vl[3] = 3;
    vo[4] = 32'h0000_0000; vr[4] = 32'h0000_0000; vd[4] = 1'b0;
    vf[4] = 1'b1; va[4] = 5'd0; vl[4] = 2;
    for (int i = 0; i < 5; i++) begin
      doReq(vo[i], vr[i], vd[i], lat);
      checkResult($sformatf("vec%0d", i), vf[i], va[i], vl[i], lat);
      refFind(vo[i], vr[i], vd[i], mf, ma);
      checks++;
      if (found !== mf || shift_amt !== ma) begin
        errors++;
        $display("FAIL vec%0d model: got %b/%0d want %b/%0d",
                 i, found, shift_amt, mf, ma);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    doReq(32'h0000_0001, 32'h0000_0010, 1'b0, lat);
    checkResult("bp", 1'b1, 5'd4, 6, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      orig_data = $urandom;
      rot_data  = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || found !== 1'b1 ||
          shift_amt !== 5'd4 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%b f=%b a=%0d r=%b want 1/1/4/0",
                 i, out_valid, found, shift_amt, in_ready);
      end
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    @(negedge clk);
    in_valid  = 1'b1;
    orig_data = 32'h1234_5678;
    rot_data  = 32'h1234_5679;
    dir       = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: vld=%b rdy=%b want 0/1",
               out_valid, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_abort: got %0d valid cycles want 0", seen);
    end
    doReq(32'h0000_00F0, 32'h0000_000F, 1'b1, lat);
    checkResult("post_rst", 1'b1, 5'd4, 6, lat);
    drain();
  endtask

  task automatic test_scoreboard();
    logic [31:0] o;
    logic [31:0] r;
    logic        d;
    int          k;
    int          lat;
    logic        mf;
    logic [4:0]  ma;
    for (int i = 0; i < 6; i++) begin
      o = $urandom;
      d = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 31);
      if (i == 5) begin
        r = o ^ 32'h0000_0001;
      end else if (d) begin
        r = (o >> k) | (o << (32 - k));
      end else begin
        r = (o << k) | (o >> (32 - k));
      end
      refFind(o, r, d, mf, ma);
      doReq(o, r, d, lat);
      checkResult($sformatf("sb%0d", i), mf, ma,
                  mf ? 2 + int'(ma) : 33, lat);
      drain();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_scoreboard();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
